booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
Sequential signed 32x32 multiplier for the Mini SRC datapath. It uses radix-4 (modified) Booth recoding and produces the 64-bit product as HI/LO words for the MUL instruction. It is the multiply counterpart to the sequential divider and shares the same Z[63:32]/Z[31:0] result convention. The control unit drives it through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits. Must be even. Product is 2*WIDTH bits; iteration count is WIDTH/2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request a multiply. Sampled only in IDLE or DONE.
- multiplicand  in  WIDTH  M, two's complement. Sampled on the accepting edge.
- multiplier  in  WIDTH  Q, two's complement. Sampled on the accepting edge.
- busy  out  1  high while iterating (RUN).
- done  out  1  one-cycle pulse; product valid from this cycle onward.
- product_lo  out  WIDTH  product[WIDTH-1:0] (Z low).
- product_hi  out  WIDTH  product[2*WIDTH-1:WIDTH] (Z high).

Behaviour:
- Reset (resetn=0 at an edge): state goes to IDLE. busy=0, done=0, product_hi=0, product_lo=0, iteration counter=0. Reset takes priority over start and aborts any RUN immediately; the partial product is discarded.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch M and Q, clear the accumulator, set counter=0, go to RUN. Otherwise stay.
- RUN: busy=1. Each edge performs one radix-4 Booth step:
  - Recode triplet {Q[1],Q[0],q_-1} (q_-1 initialised to 0) to a digit in {0,+M,+2M,-M,-2M}.
  - Add the selected value into the upper accumulator, which is WIDTH+2 bits with M sign-extended.
  - Arithmetic-shift {acc,Q,q_-1} right by 2.
  - Increment counter. After the step where counter reaches WIDTH/2-1, go to DONE.
  - start is ignored in RUN; operands do not change.
- DONE: busy=0, done=1 for exactly this cycle. product_hi/product_lo are registered and hold the final result.
  - If start=1 in DONE: accept new operands as in IDLE and go directly to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N; the last Booth step occurs at edge N+WIDTH/2 (N+16); done is high in the cycle following that edge. Start-to-done is 17 cycles for WIDTH=32.
- Outputs hold the last result through IDLE until the next accepted start. During RUN they keep the previous result; intermediate values are never exposed.
- Width rules:
  - The accumulator carries 2 guard bits so that ±2M with M=-2^(WIDTH-1) cannot overflow.
  - The final 2*WIDTH product is exact for all operand pairs; no saturation and no overflow flag.
  - Examples: (-2^31)*(-2^31)=+2^62; (-2^31)*(-1)=+2^31, which appears as hi=0x00000000, lo=0x80000000.
- Zero operands run the full 16 iterations; there is no early termination.

Decomposition:
- Package mul_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - booth_sel_t enum {SEL_ZERO, SEL_PM, SEL_P2M, SEL_NM, SEL_N2M}.
  - Localparam ITER = WIDTH/2.
- One sub-module, booth_r4_recode: combinational; 3-bit triplet in, booth_sel_t out. Maps 000/111->ZERO, 001/010->PM, 011->P2M, 100->N2M, 101/110->NM.
- Top level holds the FSM, counter, accumulator/shift register and output registers.

Test Plan:
- M=6, Q=7, start pulse -> done exactly 17 cycles after accept; hi=0x00000000, lo=0x0000002A; busy high for 16 cycles.
- M=-3 (0xFFFFFFFD), Q=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000; M=Q=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Start 6*7, pulse start with M=2, Q=2 at cycle 5 of RUN -> ignored; result is 42. Then assert start with 2*2 during the done cycle -> new RUN begins next edge; second done 17 cycles later with lo=4.
- Start 0x12345678*0x9ABCDEF0, drop resetn for one edge at cycle 8 of RUN -> next cycle busy=0, done=0, hi=lo=0. No done pulse appears afterwards.
- Random signed pairs (≥1000) checked against a 64-bit signed reference product. Also check that done is never high for two consecutive cycles without an intervening accepted start.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package mul_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned ITER      = DEF_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_PM,
        SEL_P2M,
        SEL_NM,
        SEL_N2M
    } booth_sel_t;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Start/busy/done handshake and operand/result bus for booth_mul_seq.
interface booth_mul_seq_if #(
    parameter int unsigned WIDTH = mul_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_lo, product_hi
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_lo, product_hi
    );
endinterface

// File: rtl/booth_mul_seq_recode.sv
// Radix-4 Booth digit recoder: {q[i+1], q[i], q[i-1]} -> partial-product select.
module booth_r4_recode
    import mul_pkg::*;
(
    input  logic [2:0] triplet,
    output booth_sel_t sel
);

    always_comb begin
        sel = SEL_ZERO;
        case (triplet)
            3'b001, 3'b010: sel = SEL_PM;
            3'b011:         sel = SEL_P2M;
            3'b100:         sel = SEL_N2M;
            3'b101, 3'b110: sel = SEL_NM;
            default:        sel = SEL_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTHxWIDTH radix-4 Booth multiplier producing a HI/LO product.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           resetn,
    booth_mul_seq_if.slave bus
);

    localparam int unsigned N_ITER = WIDTH / 2;
    localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int unsigned AW     = WIDTH + 2;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    m_reg;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    booth_sel_t       sel;
    logic             accept;
    logic             last_step;

    booth_r4_recode u_recode (
        .triplet ({q_reg[1:0], q_m1}),
        .sel     (sel)
    );

    // Two guard bits in m_reg/acc keep +-2M exact even for the most negative M.
    always_comb begin
        addend = '0;
        case (sel)
            SEL_PM:  addend = m_reg;
            SEL_P2M: addend = m_reg << 1;
            SEL_NM:  addend = -m_reg;
            SEL_N2M: addend = -(m_reg << 1);
            default: addend = '0;
        endcase
    end

    assign sum    = acc + addend;
    assign acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_nx   = {sum[1:0], q_reg[WIDTH-1:2]};

    assign accept    = bus.start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (cnt == CW'(N_ITER - 1));

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt    <= '0;
            m_reg  <= '0;
            acc    <= '0;
            q_reg  <= '0;
            q_m1   <= 1'b0;
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (accept) begin
            m_reg <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            q_reg <= bus.multiplier;
            q_m1  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nx;
            q_reg <= q_nx;
            q_m1  <= q_reg[1];
            cnt   <= cnt + 1'b1;
            // Results are published only on the final step so RUN never exposes partials.
            if (last_step) begin
                hi_reg <= acc_nx[WIDTH-1:0];
                lo_reg <= q_nx;
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.product_hi = hi_reg;
    assign bus.product_lo = lo_reg;

endmodule
